// File: rtl/sonar_ranger_if.sv
// Data-memory bus bundle shared by the processor side and the sonar_ranger
// slave: word address, write strobe, write data and registered read data.
interface sonar_ranger_if;
    logic [11:0] addr;
    logic        wEn;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    modport master (output addr, output wEn, output dataIn, input dataOut);
    modport slave  (input addr, input wEn, input dataIn, output dataOut);
endinterface

// File: rtl/sonar_ranger.sv
// Memory-mapped HC-SR04 style ranger: trigger generation, echo timing, cm conversion.
// Optional feature macro: SONAR_AUTO_EN (writable auto bit, back-to-back measurements).
module sonar_ranger #(
    parameter logic [11:0] BASE_ADDR      = 12'hF00,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned CYCLES_PER_CM  = 2900,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned HOLDOFF_CYCLES = 3_000_000
) (
    input  logic           clock,
    input  logic           reset,
    sonar_ranger_if.slave  bus,
    input  logic           echo,
    output logic           trig
);

    localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] CPM_LAST     = 32'(CYCLES_PER_CM - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST    = 32'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    state_t      state_r;
    logic        echo_meta_r;
    logic        echo_sync_r;
    logic [15:0] dist_r;
    logic [31:0] raw_r;
    logic [31:0] sub_cnt_r;
    logic [31:0] phase_cnt_r;
    logic [31:0] to_cnt_r;
    logic        valid_r;
    logic        timeout_r;
    logic        auto_s;

    logic [11:0] offset_s;
    logic        hit_s;
    logic        wr_ctrl_s;
    logic        start_s;
    logic        clear_s;
    logic        busy_s;
    logic [31:0] status_s;
    logic [31:0] rd_data_s;
    logic [31:0] raw_inc_s;
    logic [31:0] sub_next_s;
    logic [15:0] dist_next_s;
    logic        unused_s;

    assign offset_s  = bus.addr - BASE_ADDR;
    assign hit_s     = (bus.addr >= BASE_ADDR) && (offset_s <= 12'd2);
    assign wr_ctrl_s = bus.wEn && hit_s && (offset_s == 12'd0);
    assign start_s   = wr_ctrl_s && bus.dataIn[0];
    assign clear_s   = wr_ctrl_s && bus.dataIn[2];
    assign busy_s    = (state_r != ST_IDLE);
    assign status_s  = {27'd0, timeout_r, valid_r, busy_s, auto_s, 1'b0};
    assign unused_s  = ^{bus.dataIn[31:3], bus.dataIn[1]};

`ifdef SONAR_AUTO_EN
    logic auto_r;

    // auto bit is rewritten by every CTRL write
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            auto_r <= bus.dataIn[1];
        end else begin
            auto_r <= auto_r;
        end
    end

    assign auto_s = auto_r;
`else
    assign auto_s = 1'b0;
`endif

    // Saturating next values for one echo-high clock
    always_comb begin
        raw_inc_s   = raw_r;
        sub_next_s  = sub_cnt_r;
        dist_next_s = dist_r;
        if (raw_r != 32'hFFFF_FFFF) begin
            raw_inc_s = raw_r + 32'd1;
        end else begin
            raw_inc_s = raw_r;
        end
        if (sub_cnt_r == CPM_LAST) begin
            sub_next_s = 32'd0;
            if (dist_r != 16'hFFFF) begin
                dist_next_s = dist_r + 16'd1;
            end else begin
                dist_next_s = dist_r;
            end
        end else begin
            sub_next_s  = sub_cnt_r + 32'd1;
            dist_next_s = dist_r;
        end
    end

    // Read mux; anything outside the three registers reads as zero
    always_comb begin
        rd_data_s = 32'd0;
        if (hit_s) begin
            case (offset_s)
                12'd0:   rd_data_s = status_s;
                12'd1:   rd_data_s = {16'd0, dist_r};
                12'd2:   rd_data_s = raw_r;
                default: rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    // Registered read data, RAM-compatible one-cycle latency
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.dataOut <= 32'd0;
        end else begin
            bus.dataOut <= rd_data_s;
        end
    end

    // Two-flop synchronizer for the asynchronous echo pin
    always_ff @(posedge clock) begin
        if (reset) begin
            echo_meta_r <= 1'b0;
            echo_sync_r <= 1'b0;
        end else begin
            echo_meta_r <= echo;
            echo_sync_r <= echo_meta_r;
        end
    end

    // Measurement FSM with registered trigger output and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            trig        <= 1'b0;
            dist_r      <= 16'd0;
            raw_r       <= 32'd0;
            sub_cnt_r   <= 32'd0;
            phase_cnt_r <= 32'd0;
            to_cnt_r    <= 32'd0;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            // Clear is applied first so a result latch in the same cycle overrides it
            if (clear_s) begin
                valid_r   <= 1'b0;
                timeout_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_TRIG;
                        trig        <= 1'b1;
                        phase_cnt_r <= 32'd0;
                        dist_r      <= 16'd0;
                        raw_r       <= 32'd0;
                        sub_cnt_r   <= 32'd0;
                    end
                end
                ST_TRIG: begin
                    if (phase_cnt_r == TRIG_LAST) begin
                        state_r  <= ST_WAIT_RISE;
                        trig     <= 1'b0;
                        to_cnt_r <= 32'd0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 32'd1;
                    end
                end
                ST_WAIT_RISE: begin
                    if (to_cnt_r == TIMEOUT_LAST) begin
                        dist_r      <= 16'hFFFF;
                        valid_r     <= 1'b1;
                        timeout_r   <= 1'b1;
                        state_r     <= ST_HOLDOFF;
                        phase_cnt_r <= 32'd0;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                        // An echo already high is counted from this very cycle
                        if (echo_sync_r) begin
                            raw_r     <= raw_inc_s;
                            sub_cnt_r <= sub_next_s;
                            dist_r    <= dist_next_s;
                            state_r   <= ST_MEASURE;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (!echo_sync_r) begin
                        valid_r     <= 1'b1;
                        state_r     <= ST_HOLDOFF;
                        phase_cnt_r <= 32'd0;
                    end else if (to_cnt_r == TIMEOUT_LAST) begin
                        dist_r      <= 16'hFFFF;
                        valid_r     <= 1'b1;
                        timeout_r   <= 1'b1;
                        state_r     <= ST_HOLDOFF;
                        phase_cnt_r <= 32'd0;
                    end else begin
                        to_cnt_r  <= to_cnt_r + 32'd1;
                        raw_r     <= raw_inc_s;
                        sub_cnt_r <= sub_next_s;
                        dist_r    <= dist_next_s;
                    end
                end
                ST_HOLDOFF: begin
                    if (phase_cnt_r == HOLD_LAST) begin
                        if (auto_s) begin
                            state_r     <= ST_TRIG;
                            trig        <= 1'b1;
                            phase_cnt_r <= 32'd0;
                            dist_r      <= 16'd0;
                            raw_r       <= 32'd0;
                            sub_cnt_r   <= 32'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    trig    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed self-checking bench for sonar_ranger with short timing parameters.
module tb_sonar_ranger;

    logic clock = 1'b0;
    logic reset;
    logic echo;
    logic trig;
    int   tests = 0;
    int   fails = 0;
    int   rises = 0;
    int   highs = 0;
    logic trig_q = 1'b0;
    int   r0;
    int   h0;
    logic [31:0] rd;

    sonar_ranger_if bus ();

    sonar_ranger #(
        .BASE_ADDR      (12'hF00),
        .TRIG_CYCLES    (10),
        .CYCLES_PER_CM  (4),
        .TIMEOUT_CYCLES (200),
        .HOLDOFF_CYCLES (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .echo  (echo),
        .trig  (trig)
    );

    always #5 clock = ~clock;

    // Trigger pulse monitor sampled mid-cycle
    always @(negedge clock) begin
        trig_q <= trig;
        if (trig === 1'b1 && trig_q === 1'b0) rises <= rises + 1;
        if (trig === 1'b1) highs <= highs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.wEn  = 1'b0;
        @(posedge clock);
        #1;
        d = bus.dataOut;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] v);
        bus.addr   = a;
        bus.wEn    = 1'b1;
        bus.dataIn = v;
        @(posedge clock);
        #1;
        bus.wEn    = 1'b0;
        bus.dataIn = 32'd0;
    endtask

    task automatic wait_trig_low();
        for (int i = 0; i < 40; i++) begin
            if (trig === 1'b0) break;
            @(posedge clock);
            #1;
        end
        check("trig_falls", {31'd0, trig}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        echo       = 1'b0;
        bus.addr   = 12'h000;
        bus.wEn    = 1'b0;
        bus.dataIn = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        check("reset_trig", {31'd0, trig}, 32'd0);
        bus_rd(12'hF00, rd); check("reset_ctrl", rd, 32'd0);
        bus_rd(12'hF01, rd); check("reset_dist", rd, 32'd0);
        bus_rd(12'hF02, rd); check("reset_raw", rd, 32'd0);

        // Normal 40-clock echo
        r0 = rises; h0 = highs;
        bus_wr(12'hF00, 32'd1);
        check("trig_rise", {31'd0, trig}, 32'd1);
        wait_trig_low();
        check("trig_width", 32'(highs - h0), 32'd10);
        check("trig_count", 32'(rises - r0), 32'd1);
        echo = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        echo = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        bus_rd(12'hF01, rd); check("dist_40", rd, 32'd10);
        bus_rd(12'hF02, rd); check("raw_40", rd, 32'd40);
        bus_rd(12'hF00, rd); check("status_holdoff", rd, 32'h0C);
        repeat (14) @(posedge clock);
        #1;
        bus_rd(12'hF00, rd); check("status_hold_m2", rd, 32'h0C);
        bus_rd(12'hF00, rd); check("status_hold_m1", rd, 32'h0C);
        bus_rd(12'hF00, rd); check("status_idle", rd, 32'h08);

        // Timeout with echo never asserted
        bus_wr(12'hF00, 32'd4);
        bus_wr(12'hF00, 32'd1);
        repeat (209) @(posedge clock);
        #1;
        bus_rd(12'hF00, rd); check("status_pre_to", rd, 32'h04);
        bus_rd(12'hF00, rd); check("status_timeout", rd, 32'h1C);
        bus_rd(12'hF01, rd); check("dist_timeout", rd, 32'h0000_FFFF);
        repeat (20) @(posedge clock);
        #1;
        bus_wr(12'hF00, 32'd4);
        bus_rd(12'hF00, rd); check("status_cleared", rd, 32'd0);

        // Start while busy is dropped
        r0 = rises;
        bus_wr(12'hF00, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        bus_wr(12'hF00, 32'd1);
        wait_trig_low();
        echo = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        echo = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("no_extra_trig", 32'(rises - r0), 32'd1);
        bus_rd(12'hF00, rd); check("status_busy_drop", rd, 32'h08);

        // Read-only registers and out-of-range addresses
        bus_wr(12'hF01, 32'h1234);
        bus_rd(12'hF01, rd); check("dist_ro", rd, 32'd2);
        bus_rd(12'hF02, rd); check("raw_8", rd, 32'd8);
        bus_rd(12'h123, rd); check("addr_123", rd, 32'd0);
        bus_rd(12'hF03, rd); check("addr_f03", rd, 32'd0);

        // Reset during trigger
        bus_wr(12'hF00, 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check("trig_mid", {31'd0, trig}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("trig_reset", {31'd0, trig}, 32'd0);
        reset = 1'b0;

        // Reset during measurement
        bus_wr(12'hF00, 32'd1);
        repeat (11) @(posedge clock);
        #1;
        echo = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        bus_rd(12'hF00, rd); check("status_measure", rd, 32'h04);
        reset = 1'b1;
        echo  = 1'b0;
        @(posedge clock);
        #1;
        check("trig_reset_meas", {31'd0, trig}, 32'd0);
        check("dataout_reset", bus.dataOut, 32'd0);
        reset = 1'b0;
        bus_rd(12'hF00, rd); check("ctrl_after_rst", rd, 32'd0);
        bus_rd(12'hF01, rd); check("dist_after_rst", rd, 32'd0);
        bus_rd(12'hF02, rd); check("raw_after_rst", rd, 32'd0);

        // Auto bit
        r0 = rises;
        bus_wr(12'hF00, 32'd3);
        bus_rd(12'hF00, rd);
`ifdef SONAR_AUTO_EN
        check("status_auto", rd, 32'h06);
`else
        check("status_auto", rd, 32'h04);
`endif
        repeat (300) @(posedge clock);
        #1;
`ifdef SONAR_AUTO_EN
        check("auto_pulses", 32'(rises - r0), 32'd2);
`else
        check("auto_pulses", 32'(rises - r0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
